// File: rtl/thread_fetch_sel.sv
// Fine-grained hart selector for the multithreaded frontend: owns the fetch slot and
// rotates it round-robin after a quantum of accepted fetches, skipping ineligible harts.
module thread_fetch_sel #(
  parameter int unsigned NumThreads = 2,
  parameter int unsigned TidWidth   = (NumThreads > 1) ? $clog2(NumThreads) : 1,
  parameter int unsigned Quantum    = 1,
  parameter int unsigned CntWidth   = (Quantum > 1) ? $clog2(Quantum) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumThreads-1:0] thread_en_i,
  input  logic [NumThreads-1:0] thread_blocked_i,
  input  logic                  flush_i,
  input  logic [TidWidth-1:0]   flush_tid_i,
  input  logic                  fetch_ready_i,
  output logic                  fetch_valid_o,
  output logic [TidWidth-1:0]   fetch_tid_o,
  output logic                  switch_o
);

  logic [NumThreads-1:0] elig;
  logic [TidWidth-1:0]   cur_tid_q, cur_tid_d;
  logic [TidWidth-1:0]   rr_tid;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  switch_q, switch_d;
  logic                  rr_found;
  logic                  cur_elig;
  logic                  grant;
  logic                  flush_ok;
  logic                  quantum_end;
  int unsigned           rr_idx;

  assign elig          = thread_en_i & ~thread_blocked_i;
  assign cur_elig      = elig[cur_tid_q];
  assign grant         = cur_elig & fetch_ready_i;
  assign quantum_end   = (cnt_q == CntWidth'(Quantum - 1));
  // Out-of-range or disabled redirect targets are dropped.
  assign flush_ok      = flush_i && (32'(flush_tid_i) < NumThreads) && thread_en_i[flush_tid_i];

  assign fetch_valid_o = cur_elig;
  assign fetch_tid_o   = cur_tid_q;
  assign switch_o      = switch_q;

  // First eligible hart after the current one, wrapping, never the current one itself.
  always_comb begin
    rr_found = 1'b0;
    rr_tid   = cur_tid_q;
    rr_idx   = 0;
    for (int unsigned i = 1; i < NumThreads; i++) begin
      rr_idx = (32'(cur_tid_q) + i) % NumThreads;
      if (!rr_found && elig[rr_idx]) begin
        rr_found = 1'b1;
        rr_tid   = TidWidth'(rr_idx);
      end
    end
  end

  always_comb begin
    cur_tid_d = cur_tid_q;
    cnt_d     = cnt_q;
    if (flush_ok) begin
      cur_tid_d = flush_tid_i;
      cnt_d     = '0;
    end else if (!cur_elig) begin
      if (rr_found) begin
        cur_tid_d = rr_tid;
        cnt_d     = '0;
      end
    end else if (grant && quantum_end) begin
      if (rr_found) begin
        cur_tid_d = rr_tid;
      end
      cnt_d = '0;
    end else if (grant) begin
      cnt_d = cnt_q + 1'b1;
    end
    switch_d = (cur_tid_d != cur_tid_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_tid_q <= '0;
      cnt_q     <= '0;
      switch_q  <= 1'b0;
    end else begin
      cur_tid_q <= cur_tid_d;
      cnt_q     <= cnt_d;
      switch_q  <= switch_d;
    end
  end

endmodule

// File: tb/tb_thread_fetch_sel.sv
// Bench for thread_fetch_sel: two 3-hart instances (Quantum 1 and 3) on shared inputs,
// directed scenarios against hand-derived tables plus a randomized run against a model.
module tb_thread_fetch_sel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] en, blk;
  logic       flush;
  logic [1:0] ftid;
  logic       rdy;

  logic       v1, s1, v3, s3;
  logic [1:0] t1, t3;

  logic       o_v [2];
  logic       o_s [2];
  logic [1:0] o_t [2];

  int checks = 0;
  int errors = 0;

  int m_cur [2];
  int m_cnt [2];
  int m_sw  [2];

  always #5 clk = ~clk;

  thread_fetch_sel #(.NumThreads(3), .Quantum(1)) dut_q1 (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .thread_en_i      (en),
    .thread_blocked_i (blk),
    .flush_i          (flush),
    .flush_tid_i      (ftid),
    .fetch_ready_i    (rdy),
    .fetch_valid_o    (v1),
    .fetch_tid_o      (t1),
    .switch_o         (s1)
  );

  thread_fetch_sel #(.NumThreads(3), .Quantum(3)) dut_q3 (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .thread_en_i      (en),
    .thread_blocked_i (blk),
    .flush_i          (flush),
    .flush_tid_i      (ftid),
    .fetch_ready_i    (rdy),
    .fetch_valid_o    (v3),
    .fetch_tid_o      (t3),
    .switch_o         (s3)
  );

  assign o_v[0] = v1;
  assign o_v[1] = v3;
  assign o_s[0] = s1;
  assign o_s[1] = s3;
  assign o_t[0] = t1;
  assign o_t[1] = t3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 3'b011;
    blk   = 3'b000;
    flush = 1'b0;
    ftid  = 2'd0;
    rdy   = 1'b1;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: eligibility and round-robin successor from the selection rules.
  function automatic bit m_elig(int t);
    return en[t] && !blk[t];
  endfunction

  function automatic int m_next_rr(int x);
    for (int i = 1; i < 3; i++) begin
      if (m_elig((x + i) % 3)) return (x + i) % 3;
    end
    return -1;
  endfunction

  task automatic model_next(int k, int q);
    int  nr;
    int  nc;
    int  ncnt;
    bit  g;
    nr   = m_next_rr(m_cur[k]);
    nc   = m_cur[k];
    ncnt = m_cnt[k];
    g    = m_elig(m_cur[k]) && rdy;
    if (flush && ftid < 3 && en[ftid]) begin
      nc   = ftid;
      ncnt = 0;
    end else if (!m_elig(m_cur[k])) begin
      if (nr >= 0) begin
        nc   = nr;
        ncnt = 0;
      end
    end else if (g && m_cnt[k] == q - 1) begin
      if (nr >= 0) nc = nr;
      ncnt = 0;
    end else if (g) begin
      ncnt = m_cnt[k] + 1;
    end
    m_sw[k]  = (nc != m_cur[k]);
    m_cur[k] = nc;
    m_cnt[k] = ncnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 3'b010;
    blk   = 3'b000;
    flush = 1'b0;
    ftid  = 2'd0;
    rdy   = 1'b1;
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_t[k] !== 2'd0 || o_s[k] !== 1'b0 || o_v[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_en010[%0d]: got t=%0d s=%0b v=%0b want t=0 s=0 v=0",
                 k, o_t[k], o_s[k], o_v[k]);
      end
    end
    tick();
    en = 3'b011;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_t[k] !== 2'd0 || o_s[k] !== 1'b0 || o_v[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_en011[%0d]: got t=%0d s=%0b v=%0b want t=0 s=0 v=1",
                 k, o_t[k], o_s[k], o_v[k]);
      end
    end
  endtask

  task automatic test_rotate();
    int et;
    int es;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #1;
      for (int k = 0; k < 2; k++) begin
        et = (k == 0) ? c % 2 : (c / 3) % 2;
        es = (k == 0) ? (c > 0) : (c > 0 && c % 3 == 0);
        checks++;
        if (o_t[k] !== 2'(et) || o_s[k] !== 1'(es) || o_v[k] !== 1'b1) begin
          errors++;
          $display("FAIL rotate[%0d] cyc %0d: got t=%0d s=%0b v=%0b want t=%0d s=%0d v=1",
                   k, c, o_t[k], o_s[k], o_v[k], et, es);
        end
      end
    end
  endtask

  task automatic test_block();
    logic [2:0] tb_blk [8] = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b011, 3'b001, 3'b010, 3'b010};
    int         et     [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int         ev     [8] = '{0, 1, 0, 0, 0, 1, 0, 1};
    int         es     [8] = '{0, 1, 0, 0, 0, 0, 0, 1};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      blk = tb_blk[c];
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_t[k] !== 2'(et[c]) || o_v[k] !== 1'(ev[c]) || o_s[k] !== 1'(es[c])) begin
          errors++;
          $display("FAIL block[%0d] cyc %0d: got t=%0d v=%0b s=%0b want t=%0d v=%0d s=%0d",
                   k, c, o_t[k], o_v[k], o_s[k], et[c], ev[c], es[c]);
        end
      end
    end
  endtask

  task automatic test_ready_low();
    int et [2];
    int es [2];
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      rdy = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
      #1;
      et[0] = (c < 3) ? c % 2 : ((c <= 8) ? 1 : (((c - 8) % 2 == 1) ? 0 : 1));
      es[0] = (c >= 1 && (c <= 3 || c >= 9));
      et[1] = (c < 3) ? 0 : ((c <= 10) ? 1 : 0);
      es[1] = (c == 3 || c == 11);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_t[k] !== 2'(et[k]) || o_s[k] !== 1'(es[k]) || o_v[k] !== 1'b1) begin
          errors++;
          $display("FAIL ready_low[%0d] cyc %0d: got t=%0d s=%0b v=%0b want t=%0d s=%0d v=1",
                   k, c, o_t[k], o_s[k], o_v[k], et[k], es[k]);
        end
      end
    end
    rdy = 1'b1;
  endtask

  task automatic test_flush();
    int et1 [15] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 2, 1, 2, 0, 1, 2};
    int es1 [15] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int et3 [15] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    int es3 [15] = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int et;
    int es;
    apply_reset();
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      if (c == 4) begin
        en = 3'b011; flush = 1'b1; ftid = 2'd0;
      end else if (c >= 8 && c <= 10) begin
        en = 3'b110; flush = 1'b1; ftid = 2'd0;
      end else if (c >= 11) begin
        en = 3'b111; flush = 1'b1; ftid = 2'd3;
      end else begin
        en = 3'b011; flush = 1'b0; ftid = 2'd0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        et = (k == 0) ? et1[c] : et3[c];
        es = (k == 0) ? es1[c] : es3[c];
        checks++;
        if (o_t[k] !== 2'(et) || o_s[k] !== 1'(es) || o_v[k] !== 1'b1) begin
          errors++;
          $display("FAIL flush[%0d] cyc %0d: got t=%0d s=%0b v=%0b want t=%0d s=%0d v=1",
                   k, c, o_t[k], o_s[k], o_v[k], et, es);
        end
      end
    end
    flush = 1'b0;
    en    = 3'b011;
  endtask

  task automatic test_async_reset();
    int et;
    apply_reset();
    for (int c = 1; c <= 5; c++) tick();
    #1;
    checks++;
    if (t3 !== 2'd1 || t1 !== 2'd1) begin
      errors++;
      $display("FAIL areset_pre: got t1=%0d t3=%0d want t1=1 t3=1", t1, t3);
    end
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_t[k] !== 2'd0 || o_s[k] !== 1'b0 || o_v[k] !== 1'b1) begin
        errors++;
        $display("FAIL areset_now[%0d]: got t=%0d s=%0b v=%0b want t=0 s=0 v=1",
                 k, o_t[k], o_s[k], o_v[k]);
      end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_t[k] !== 2'd0 || o_s[k] !== 1'b0) begin
        errors++;
        $display("FAIL areset_hold[%0d]: got t=%0d s=%0b want t=0 s=0", k, o_t[k], o_s[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      #1;
      for (int k = 0; k < 2; k++) begin
        et = (k == 0) ? c % 2 : ((c < 3) ? 0 : 1);
        checks++;
        if (o_t[k] !== 2'(et)) begin
          errors++;
          $display("FAIL areset_restart[%0d] cyc %0d: got t=%0d want t=%0d", k, c, o_t[k], et);
        end
      end
    end
  endtask

  task automatic test_random();
    int exp_v;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      m_cur[k] = 0;
      m_cnt[k] = 0;
      m_sw[k]  = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) tick();
      en    = 3'($urandom | $urandom);
      blk   = 3'($urandom & $urandom);
      flush = ($urandom_range(0, 7) == 0);
      ftid  = 2'($urandom_range(0, 3));
      rdy   = ($urandom_range(0, 3) != 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        exp_v = m_elig(m_cur[k]);
        checks++;
        if (o_t[k] !== 2'(m_cur[k]) || o_s[k] !== 1'(m_sw[k]) || o_v[k] !== 1'(exp_v)) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: got t=%0d s=%0b v=%0b want t=%0d s=%0d v=%0d",
                   k, c, o_t[k], o_s[k], o_v[k], m_cur[k], m_sw[k], exp_v);
        end
      end
      model_next(0, 1);
      model_next(1, 3);
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_block();
    test_ready_low();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thread_fetch_sel.md
# thread_fetch_sel

Fine-grained hardware-thread selector for the multithreaded CVA6 frontend. Each cycle it picks which hart (0..NumThreads-1) owns the fetch slot. It presents that thread ID to the frontend/icache request stage with a valid/ready handshake. Threads rotate round-robin after a configurable quantum of accepted fetches. Blocked or disabled threads are skipped, and a redirect (flush) immediately hands the slot to the redirected thread.

## Interface
Parameters:
- NumThreads, 2, number of hardware threads; must be ≥ 1.
- TidWidth, max(1, $clog2(NumThreads)), width of the thread ID.
- Quantum, 1, number of accepted fetches a thread owns before rotating; must be ≥ 1.
- CntWidth, max(1, $clog2(Quantum)), width of the quantum counter.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- thread_en_i  in  NumThreads  per-thread enable (hart running, not halted)
- thread_blocked_i  in  NumThreads  per-thread fetch block (icache miss outstanding, WFI)
- flush_i  in  1  redirect request
- flush_tid_i  in  TidWidth  thread being redirected
- fetch_ready_i  in  1  frontend accepts the current selection
- fetch_valid_o  out  1  selected thread may fetch this cycle
- fetch_tid_o  out  TidWidth  selected thread ID
- switch_o  out  1  one-cycle pulse: fetch_tid_o changed on the previous clock edge

## Operation
- Internal state: cur_tid_q (drives fetch_tid_o), cnt_q (accepted fetches in the current quantum), switch_q (drives switch_o).
- elig(t) = thread_en_i[t] & ~thread_blocked_i[t].
- fetch_valid_o = elig(cur_tid_q). This is combinational from the inputs and cur_tid_q.
- grant = fetch_valid_o & fetch_ready_i.
- next_rr(x) is the first eligible thread in the order x+1, x+2, …, wrapping modulo NumThreads and excluding x itself. If no such thread exists, next_rr(x) is none.
- Next-state priority, evaluated each cycle (first match wins):
  1. flush_i & thread_en_i[flush_tid_i]: cur <= flush_tid_i; cnt <= 0. This applies even if cur already equals flush_tid_i, which restarts its quantum. It applies even if that thread is blocked.
  2. ~elig(cur_tid_q): if next_rr exists, cur <= next_rr and cnt <= 0; otherwise hold both.
  3. grant & (cnt_q == Quantum-1): if next_rr exists, cur <= next_rr; otherwise hold cur. In both cases cnt <= 0.
  4. grant: cnt <= cnt_q + 1.
  5. Otherwise hold.
- A flush to a disabled thread (thread_en_i[flush_tid_i]=0) is ignored; rules 2–5 apply instead.
- A flush_tid_i value ≥ NumThreads is ignored.
- switch_q <= (cur_d != cur_tid_q).
- Reset values: cur_tid_q=0, cnt_q=0, switch_q=0. Hence fetch_tid_o=0 and switch_o=0 in reset, and fetch_valid_o = elig(0).
- NumThreads=1: cur is always 0, switch_o is never asserted, and the block degenerates to fetch_valid_o = elig(0).

## Timing
- Rotation latency is 1 cycle: a grant ending a quantum in cycle n gives the new fetch_tid_o in cycle n+1, with switch_o=1 in cycle n+1.
- Block response: when the current thread becomes blocked in cycle n, fetch_valid_o drops in cycle n. cur moves at the edge ending cycle n. If another thread is eligible, fetch_valid_o=1 again in n+1 (one bubble).
- Flush: flush_i in cycle n gives fetch_tid_o=flush_tid_i in cycle n+1. Any grant in cycle n still counts as a fetch for the old thread on the frontend side, but the counter result is overridden by the flush.
- fetch_ready_i without fetch_valid_o changes no state.
- fetch_tid_o never changes except at a clock edge. It is stable while fetch_valid_o=1 and fetch_ready_i=0, unless a flush arrives or the thread becomes blocked.
- Asynchronous reset mid-operation forces the reset values immediately; no grant is counted in that cycle.

## Test plan
- Reset, both threads enabled and unblocked, ready=1, Quantum=1: fetch_tid_o sequence 0,1,0,1…; switch_o=1 every cycle from cycle 1; fetch_valid_o=1 throughout.
- Quantum=3, ready=1: tid 0 for 3 grants, then tid 1 for 3 grants. cnt wraps 0→1→2→0. switch_o pulses once per 3 cycles.
- Thread 0 blocked in cycle 4 while current: fetch_valid_o=0 in cycle 4, fetch_tid_o=1 with valid=1 in cycle 5. If both threads are blocked, valid stays 0 and tid holds; unblocking either resumes that thread the same cycle if it is current, otherwise the next cycle.
- Ready held low for 5 cycles with tid=1: no rotation, tid stable, cnt unchanged, switch_o=0.
- Flush to tid 0 while tid 1 is mid-quantum (Quantum=3, cnt=1): tid=0 with cnt=0 next cycle and switch_o=1. Flush to tid 0 with thread_en_i[0]=0: ignored, normal rotation continues.
- Assert rst_ni low while tid=1 and cnt=2: outputs become tid=0, switch_o=0 asynchronously. After release, the sequence restarts from thread 0.
